// File: rtl/mips_pc_alu_core.sv
// PC register, PC+4 / branch-target adders and the 32-bit MIPS ALU of the single-cycle datapath.
// Define ALU_OVERFLOW_EN to drive the signed-overflow flag for ADD/SUB; otherwise overflow is tied low.
module mips_pc_alu_core #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_next,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  input  logic [31:0]     imm_ext,
  output logic [PC_W-1:0] pc_branch,
  input  logic [31:0]     src_a,
  input  logic [31:0]     src_b,
  input  logic [5:0]      alu_ctrl,
  input  logic [4:0]      shamt,
  output logic [31:0]     alu_result,
  output logic            zero,
  output logic            overflow
);

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_LUI  = 6'h0F;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  logic [PC_W-1:0]        pc_q, pc_d;
  logic signed [31:0]     imm_s;
  logic signed [PC_W-1:0] br_off;
  logic signed [31:0]     a_s, b_s;
  logic [31:0]            sum, diff;
  logic [31:0]            result;

  // PC register: loads every cycle, reset wins over pc_next
  always_comb begin
    pc_d = pc_next;
    if (reset) pc_d = RESET_PC;
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  assign pc = pc_q;

  // Word offset is sign-extended to PC_W so negative immediates branch backward
  assign imm_s     = imm_ext;
  assign br_off    = PC_W'(imm_s <<< 2);
  assign pc_plus4  = pc_q + PC_W'(4);
  assign pc_branch = pc_plus4 + br_off;

  assign a_s  = src_a;
  assign b_s  = src_b;
  assign sum  = src_a + src_b;
  assign diff = src_a - src_b;

  always_comb begin
    result = 32'h0;
    unique case (alu_ctrl)
      F_SLL:          result = src_b << shamt;
      F_SRL:          result = src_b >> shamt;
      F_SRA:          result = b_s >>> shamt;
      F_SLLV:         result = src_b << src_a[4:0];
      F_SRLV:         result = src_b >> src_a[4:0];
      F_SRAV:         result = b_s >>> src_a[4:0];
      F_JR:           result = src_a;
      F_LUI:          result = {src_b[15:0], 16'h0000};
      F_ADD, F_ADDU:  result = sum;
      F_SUB, F_SUBU:  result = diff;
      F_AND:          result = src_a & src_b;
      F_OR:           result = src_a | src_b;
      F_XOR:          result = src_a ^ src_b;
      F_NOR:          result = ~(src_a | src_b);
      F_SLT:          result = {31'b0, a_s < b_s};
      F_SLTU:         result = {31'b0, src_a < src_b};
      default:        result = 32'h0;
    endcase
  end

  assign alu_result = result;
  assign zero       = (result == 32'h0);

`ifdef ALU_OVERFLOW_EN
  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    return (a[31] == b[31]) && (r[31] != a[31]);
  endfunction

  function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    return (a[31] != b[31]) && (r[31] != a[31]);
  endfunction

  always_comb begin
    overflow = 1'b0;
    if (alu_ctrl == F_ADD) overflow = add_ovf(src_a, src_b, sum);
    else if (alu_ctrl == F_SUB) overflow = sub_ovf(src_a, src_b, diff);
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mips_pc_alu_core.sv
// Directed bench for mips_pc_alu_core: PC reset/load, adders and every ALU function group.
module tb_mips_pc_alu_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_next, pc, pc_plus4, imm_ext, pc_branch;
  logic [31:0] src_a, src_b, alu_result;
  logic [5:0]  alu_ctrl;
  logic [4:0]  shamt;
  logic        zero, overflow;

  int n_cmp = 0;
  int n_err = 0;

`ifdef ALU_OVERFLOW_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  mips_pc_alu_core #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .pc_next(pc_next), .pc(pc), .pc_plus4(pc_plus4),
    .imm_ext(imm_ext), .pc_branch(pc_branch), .src_a(src_a), .src_b(src_b),
    .alu_ctrl(alu_ctrl), .shamt(shamt), .alu_result(alu_result), .zero(zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic edge_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    alu_ctrl = f; src_a = a; src_b = b; shamt = sh;
    #1;
  endtask

  initial begin
    reset = 1'b1; pc_next = 32'h1234; imm_ext = 32'h0;
    src_a = 32'h0; src_b = 32'h0; alu_ctrl = 6'h20; shamt = 5'd0;

    edge_cycle();
    edge_cycle();
    chk("reset_pc", pc, 32'h0);
    chk("reset_pc_plus4", pc_plus4, 32'h4);

    reset = 1'b0; pc_next = 32'h40;
    edge_cycle();
    chk("load_pc", pc, 32'h40);
    chk("load_pc_plus4", pc_plus4, 32'h44);

    reset = 1'b1; pc_next = 32'h80;
    edge_cycle();
    chk("midrun_reset_pc", pc, 32'h0);

    reset = 1'b0; pc_next = 32'h100; imm_ext = 32'hFFFF_FFFE;
    edge_cycle();
    chk("pc_0x100", pc, 32'h100);
    chk("branch_back", pc_branch, 32'hFC);
    imm_ext = 32'h0000_0010;
    #1;
    chk("branch_fwd", pc_branch, 32'h144);

    pc_next = 32'hFFFF_FFFC; imm_ext = 32'h1;
    edge_cycle();
    chk("plus4_wrap", pc_plus4, 32'h0);
    chk("branch_wrap", pc_branch, 32'h4);

    alu(6'h20, 32'd5, 32'd7, 5'd0);
    chk("add_5_7", alu_result, 32'd12);
    chk("add_5_7_zero", {31'b0, zero}, 32'd0);
    alu(6'h22, 32'd9, 32'd9, 5'd0);
    chk("sub_9_9", alu_result, 32'd0);
    chk("sub_9_9_zero", {31'b0, zero}, 32'd1);
    alu(6'h20, 32'h7FFF_FFFF, 32'd1, 5'd0);
    chk("add_ovf_res", alu_result, 32'h8000_0000);
    chk("add_ovf_flag", {31'b0, overflow}, {31'b0, OVF_ON});
    alu(6'h21, 32'h7FFF_FFFF, 32'd1, 5'd0);
    chk("addu_res", alu_result, 32'h8000_0000);
    chk("addu_no_ovf", {31'b0, overflow}, 32'd0);
    alu(6'h22, 32'h8000_0000, 32'd1, 5'd0);
    chk("sub_ovf_res", alu_result, 32'h7FFF_FFFF);
    chk("sub_ovf_flag", {31'b0, overflow}, {31'b0, OVF_ON});
    alu(6'h23, 32'd3, 32'd5, 5'd0);
    chk("subu_wrap", alu_result, 32'hFFFF_FFFE);

    alu(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd0);
    chk("slt_neg", alu_result, 32'd1);
    alu(6'h2B, 32'hFFFF_FFFF, 32'd1, 5'd0);
    chk("sltu_big", alu_result, 32'd0);

    alu(6'h03, 32'h0, 32'h8000_0000, 5'd4);
    chk("sra", alu_result, 32'hF800_0000);
    alu(6'h02, 32'h0, 32'h8000_0000, 5'd4);
    chk("srl", alu_result, 32'h0800_0000);
    alu(6'h00, 32'h0, 32'h0000_0003, 5'd31);
    chk("sll", alu_result, 32'h8000_0000);
    alu(6'h04, 32'd33, 32'd1, 5'd0);
    chk("sllv_mask", alu_result, 32'd2);
    alu(6'h06, 32'd36, 32'hF000_0000, 5'd0);
    chk("srlv", alu_result, 32'h0F00_0000);
    alu(6'h07, 32'd8, 32'h8000_0000, 5'd0);
    chk("srav", alu_result, 32'hFF80_0000);

    alu(6'h0F, 32'h0, 32'h0000_ABCD, 5'd0);
    chk("lui", alu_result, 32'hABCD_0000);
    alu(6'h08, 32'h0040_0010, 32'h1234_5678, 5'd0);
    chk("jr", alu_result, 32'h0040_0010);
    alu(6'h3F, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7);
    chk("undef_res", alu_result, 32'h0);
    chk("undef_zero", {31'b0, zero}, 32'd1);
    alu(6'h27, 32'h0, 32'h0, 5'd0);
    chk("nor", alu_result, 32'hFFFF_FFFF);
    alu(6'h24, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0);
    chk("and", alu_result, 32'h0F00_0F00);
    alu(6'h25, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0);
    chk("or", alu_result, 32'hFFF0_FFF0);
    alu(6'h26, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0);
    chk("xor", alu_result, 32'hF0F0_F0F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_pc_alu_core.md
Name: mips_pc_alu_core

Overview:
- Execution/PC slice of the single-cycle MIPS datapath.
- Contains three parts:
  - a parameterised PC register with synchronous reset;
  - the PC+4 and branch-target adders;
  - a 32-bit combinational ALU driven by a 6-bit function code and a 5-bit shift amount.
- Result, zero flag and branch target feed the surrounding mux/regfile/memory logic.

Parameters:
- PC_W, 32, width of PC register and PC adders.
- RESET_PC, 32'h0000_0000, value loaded into PC on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- pc_next  input  PC_W  next PC value chosen by the external branch/jump/jr muxes.
- pc  output  PC_W  current PC, registered.
- pc_plus4  output  PC_W  pc + 4, combinational.
- imm_ext  input  32  sign-extended 16-bit immediate.
- pc_branch  output  PC_W  pc_plus4 + (imm_ext << 2), combinational.
- src_a  input  32  ALU operand A (rs).
- src_b  input  32  ALU operand B (rt or immediate).
- alu_ctrl  input  6  ALU function code.
- shamt  input  5  shift amount (Instr[10:6]).
- alu_result  output  32  ALU result.
- zero  output  1  high when alu_result == 0.
- overflow  output  1  signed overflow flag (see Optional Feature).

Behaviour:
- PC register:
  - On each rising clk, pc <= RESET_PC if reset, else pc_next.
  - No enable; the register loads every cycle.
  - Reset mid-run takes effect at the next edge, regardless of pc_next.
- Adders are purely combinational, modulo 2^PC_W.
  - Carry-out is discarded.
  - Wrap-around is required: pc = 32'hFFFF_FFFC gives pc_plus4 = 0.
  - Branch offset is shifted left 2 before the add; a negative imm_ext branches backward.
- ALU is purely combinational; result is valid in the same cycle. alu_ctrl encodings follow MIPS funct codes:
  - 6'h00 SLL: src_b << shamt.
  - 6'h02 SRL: src_b >> shamt, logical.
  - 6'h03 SRA: src_b >>> shamt, arithmetic.
  - 6'h04 SLLV: src_b << src_a[4:0].
  - 6'h06 SRLV: src_b >> src_a[4:0], logical.
  - 6'h07 SRAV: src_b >>> src_a[4:0], arithmetic.
  - 6'h08 JR: pass src_a, used as the jump-register target.
  - 6'h0F LUI: {src_b[15:0], 16'h0000}.
  - 6'h20 ADD, 6'h21 ADDU: src_a + src_b.
  - 6'h22 SUB, 6'h23 SUBU: src_a - src_b.
  - 6'h24 AND, 6'h25 OR, 6'h26 XOR: bitwise.
  - 6'h27 NOR: ~(src_a | src_b).
  - 6'h2A SLT: signed compare, result 32'd1 or 32'd0.
  - 6'h2B SLTU: unsigned compare, result 32'd1 or 32'd0.
  - Any other code: alu_result = 32'h0.
- ALU arithmetic rules:
  - All add/sub wrap modulo 2^32.
  - No exception or trap is raised; ADD and ADDU produce identical results.
- zero = (alu_result == 32'h0) for every code, including the undefined default (zero = 1).
- Outputs after reset:
  - pc = RESET_PC.
  - pc_plus4 = RESET_PC + 4.
  - All other outputs track their inputs combinationally.
- No X propagation from a registered state: pc is never X after the first reset edge.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- When defined:
  - overflow = 1 for ADD (6'h20) when src_a and src_b have the same sign and the result sign differs.
  - overflow = 1 for SUB (6'h22) when src_a and src_b have different signs and the result sign differs from src_a.
  - overflow = 0 for all other codes, including ADDU/SUBU.
- When not defined: overflow is tied to 0.
- alu_result is identical in both builds.

Test Plan:
- Reset/PC:
  - Assert reset for 2 cycles with pc_next = 32'h1234 -> pc = 0, pc_plus4 = 4.
  - Release reset with pc_next = 32'h0000_0040 -> pc = 32'h40 after 1 edge.
  - Then assert reset for one edge -> pc = 0 at that edge.
- Adders:
  - pc = 32'h100, imm_ext = 32'hFFFF_FFFE -> pc_branch = 32'hFC.
  - pc = 32'hFFFF_FFFC -> pc_plus4 = 32'h0.
- Arithmetic/zero:
  - ADD 5 + 7 -> 12, zero = 0.
  - SUB 9 - 9 -> 0, zero = 1.
  - ADD 32'h7FFF_FFFF + 1 -> 32'h8000_0000; overflow = 1 only with ALU_OVERFLOW_EN.
- Compare:
  - SLT with src_a = 32'hFFFF_FFFF, src_b = 1 -> 1.
  - SLTU with the same operands -> 0.
- Shifts:
  - SRA with src_b = 32'h8000_0000, shamt = 4 -> 32'hF800_0000.
  - SRL with the same operands -> 32'h0800_0000.
  - SLLV with src_a = 33, src_b = 1 -> 2 (only the low 5 bits of src_a are used).
- Misc:
  - LUI with src_b = 32'h0000_ABCD -> 32'hABCD_0000.
  - JR with src_a = 32'h0040_0010 -> alu_result = 32'h0040_0010.
  - alu_ctrl = 6'h3F -> alu_result = 0, zero = 1.
  - NOR 0, 0 -> 32'hFFFF_FFFF.
